hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RISC-V core.
- Drives stall and flush for the PC register, IF/ID, ID/EX and EX/MEM.
- Sequences the multi-cycle mul/div unit through a start/done handshake and tracks stale instruction-memory responses after a redirect.
- Provides EX-stage forwarding selects and two saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- REG_W, 5, register-index width.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- Rs1D, Rs2D  in  REG_W  source register indices in ID.
- Rs1E, Rs2E, RdE  in  REG_W  source and destination indices in EX.
- LoadE  in  1  instruction in EX is a load.
- MulDivE  in  1  instruction in EX is a mul/div.
- PCSrcE  in  1  branch taken or jump resolved in EX (redirect).
- RdM, RdW  in  REG_W  destination indices in MEM and WB.
- RegWriteM, RegWriteW  in  1  register-file write enables in MEM and WB.
- ImemReadyF  in  1  instruction memory returns InstrF this cycle.
- MdDone  in  1  mul/div result valid (single-cycle pulse).
- StallF  out  1  hold PC.
- EnableD  out  1  IF/ID load enable.
- FlushD  out  1  IF/ID clear.
- FlushE  out  1  ID/EX clear.
- StallE  out  1  hold ID/EX.
- FlushM  out  1  EX/MEM clear (bubble).
- MdStart  out  1  one-cycle start pulse to mul/div.
- ForwardAE, ForwardBE  out  2  EX operand select: 00 register file, 01 WB, 10 MEM.
- StallCycles  out  CNT_W  count of cycles with EnableD=0.
- FlushCount  out  CNT_W  count of redirect cycles.

Behaviour:
- Registered state:
  - FSM state, either RUN or MD_WAIT.
  - Discard flag.
  - The two counters.
- Reset (reset_n low, asynchronous): state=RUN, discard=0, both counters=0. MdStart is forced to 0 while reset_n is low. Every other output is combinational on current inputs and state.
- lwStall = LoadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- mdStall = (RUN & MulDivE) | (MD_WAIT & ~MdDone).
- fetchBubble = ~ImemReadyF | discard.
- Output equations:
  - StallF = (lwStall | mdStall | ~ImemReadyF) & ~PCSrcE. A redirect always loads the PC.
  - EnableD = ~(lwStall | mdStall).
  - FlushD = PCSrcE | (fetchBubble & EnableD). A held D is never cleared by a fetch bubble.
  - FlushE = lwStall | PCSrcE.
  - StallE = mdStall.
  - FlushM = mdStall.
  - MdStart = RUN & MulDivE.
- FSM transitions:
  - RUN -> MD_WAIT when MulDivE=1. MdStart pulses for exactly this one cycle.
  - MD_WAIT -> RUN on MdDone=1. There is no stall in the MdDone cycle, so the mul/div instruction advances to MEM that edge.
  - A back-to-back mul/div re-enters MD_WAIT on the next cycle and issues a new start.
  - MdDone while in RUN is ignored.
- Discard flag (imem captures PCF at the start of an access; a redirect cannot cancel an access in flight):
  - Set when PCSrcE & ~ImemReadyF.
  - Cleared when ImemReadyF & discard; that response is bubbled.
  - When PCSrcE & ImemReadyF occur together, FlushD already kills the word, so the flag is not set.
  - A repeated redirect while discard=1 leaves it at 1.
- Forwarding, evaluated for ForwardAE with Rs1E and identically for ForwardBE with Rs2E:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E.
  - Else 01 if RegWriteW & RdW!=0 & RdW==Rs1E.
  - Else 00.
  - MEM has priority over WB.
- Counters:
  - StallCycles increments on every cycle with EnableD=0.
  - FlushCount increments on every cycle with PCSrcE=1.
  - Both saturate at all-ones with no wrap.
- Exclusivity: LoadE, MulDivE and PCSrcE refer to the single instruction in EX, so they are mutually exclusive. No priority beyond the equations above is required.
- Reset asserted during MD_WAIT returns the FSM to RUN. The mul/div unit shares reset_n.

Decomposition:
- hazard_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The state encoding (RUN, MD_WAIT).
- Sub-module sat_counter (parameter CNT_W; inputs clock, reset_n, inc; output count), instantiated twice.

Test Plan:
- Load-use: LoadE=1, RdE=5, Rs2D=5 for 1 cycle -> StallF=1, EnableD=0, FlushE=1, FlushD=0; StallCycles goes 0->1.
- Mul/div: MulDivE=1, MdDone pulses 4 cycles after MdStart -> MdStart high for 1 cycle; StallE/FlushM high for 4 cycles, low in the MdDone cycle; state returns to RUN.
- Redirect during imem wait: ImemReadyF=0 with PCSrcE=1, then ImemReadyF=1 two cycles later -> StallF=0 in the redirect cycle; FlushD=1 on the returned word; discard clears; the next ready word loads with FlushD=0.
- Forwarding priority: RdM=RdW=Rs1E=7, RegWriteM=RegWriteW=1 -> ForwardAE=10. With RegWriteM=0 -> 01. With Rs1E=0 -> 00.
- Saturation and reset: CNT_W=4, hold a load-use stall for 20 cycles -> StallCycles=15 and holds. Then pulse reset_n low mid-MD_WAIT -> counters=0, state=RUN, MdStart=0 while reset_n is low.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding select codes and mul/div sequencer state encoding
package hazard_pkg;
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} md_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && !(&count)) count <= count + CNT_W'(1);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush, mul/div sequencing, stale-fetch discard and EX forwarding
// for the 5-stage core, plus stall-cycle and redirect performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic             LoadE,
  input  logic             MulDivE,
  input  logic             PCSrcE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ImemReadyF,
  input  logic             MdDone,
  output logic             StallF,
  output logic             EnableD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             StallE,
  output logic             FlushM,
  output logic             MdStart,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);
  md_state_e state_q, state_d;
  logic discard, lw_stall, md_stall, fetch_bubble;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state_q <= RUN;
    else state_q <= state_d;

  always_comb
    state_d = (state_q == RUN) ? (MulDivE ? MD_WAIT : RUN) : (MdDone ? RUN : MD_WAIT);

  // an access in flight at a redirect still returns; drop that one word
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) discard <= 1'b0;
    else discard <= !ImemReadyF && (PCSrcE || discard);

  always_comb begin
    lw_stall     = LoadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    md_stall     = (state_q == RUN) ? MulDivE : !MdDone;
    fetch_bubble = !ImemReadyF || discard;
    StallF       = (lw_stall || md_stall || !ImemReadyF) && !PCSrcE;
    EnableD      = !(lw_stall || md_stall);
    FlushD       = PCSrcE || (fetch_bubble && EnableD);
    FlushE       = lw_stall || PCSrcE;
    StallE       = md_stall;
    FlushM       = md_stall;
    MdStart      = reset_n && state_q == RUN && MulDivE;
    ForwardAE    = (RegWriteM && RdM != '0 && RdM == Rs1E) ? FWD_MEM :
                   (RegWriteW && RdW != '0 && RdW == Rs1E) ? FWD_WB : FWD_NONE;
    ForwardBE    = (RegWriteM && RdM != '0 && RdM == Rs2E) ? FWD_MEM :
                   (RegWriteW && RdW != '0 && RdW == Rs2E) ? FWD_WB : FWD_NONE;
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock(clock), .reset_n(reset_n), .inc(!EnableD), .count(StallCycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock(clock), .reset_n(reset_n), .inc(PCSrcE), .count(FlushCount)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random stimulus; expected outputs queued per cycle
// from a behavioural model and checked by an independent monitor on the falling edge.
module tb_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int REG_W = 5;
  localparam int SAT = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset_n;
  logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic LoadE, MulDivE, PCSrcE, RegWriteM, RegWriteW, ImemReadyF, MdDone;
  logic StallF, EnableD, FlushD, FlushE, StallE, FlushM, MdStart;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  always #5 clock = ~clock;

  hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .LoadE(LoadE), .MulDivE(MulDivE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ImemReadyF(ImemReadyF), .MdDone(MdDone),
    .StallF(StallF), .EnableD(EnableD), .FlushD(FlushD), .FlushE(FlushE),
    .StallE(StallE), .FlushM(FlushM), .MdStart(MdStart),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  typedef struct {
    logic stallf, enabled, flushd, flushe, stalle, flushm, mdstart;
    logic [1:0] fa, fb;
    int sc, fc;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  // model state: waiting on mul/div, stale fetch pending, event counts
  bit m_busy, m_disc;
  int m_sc, m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [REG_W-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // inputs already set; queue this cycle's expectation, then advance the model at the edge
  task automatic drive();
    exp_t e;
    bit lw, md;
    if (!reset_n) begin m_busy = 0; m_disc = 0; m_sc = 0; m_fc = 0; end
    lw = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    md = m_busy ? !MdDone : MulDivE;
    e.stallf  = (lw || md || !ImemReadyF) && !PCSrcE;
    e.enabled = !(lw || md);
    e.flushd  = PCSrcE || ((!ImemReadyF || m_disc) && e.enabled);
    e.flushe  = lw || PCSrcE;
    e.stalle  = md;
    e.flushm  = md;
    e.mdstart = reset_n && !m_busy && MulDivE;
    e.fa = fwd(Rs1E);
    e.fb = fwd(Rs2E);
    e.sc = m_sc;
    e.fc = m_fc;
    exp_q.push_back(e);
    @(posedge clock);
    if (reset_n) begin
      m_busy = m_busy ? !MdDone : MulDivE;
      if (PCSrcE && !ImemReadyF) m_disc = 1;
      else if (ImemReadyF) m_disc = 0;
      if (!e.enabled) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
      if (PCSrcE) m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
    end
    #1;
  endtask

  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {LoadE, MulDivE, PCSrcE, RegWriteM, RegWriteW, MdDone} = '0;
    ImemReadyF = 1'b1;
  endtask

  always @(negedge clock)
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("StallF", 32'(StallF), 32'(e.stallf));
      chk("EnableD", 32'(EnableD), 32'(e.enabled));
      chk("FlushD", 32'(FlushD), 32'(e.flushd));
      chk("FlushE", 32'(FlushE), 32'(e.flushe));
      chk("StallE", 32'(StallE), 32'(e.stalle));
      chk("FlushM", 32'(FlushM), 32'(e.flushm));
      chk("MdStart", 32'(MdStart), 32'(e.mdstart));
      chk("ForwardAE", 32'(ForwardAE), 32'(e.fa));
      chk("ForwardBE", 32'(ForwardBE), 32'(e.fb));
      chk("StallCycles", 32'(StallCycles), 32'(e.sc));
      chk("FlushCount", 32'(FlushCount), 32'(e.fc));
    end

  initial begin
    int r;
    idle();
    reset_n = 1'b0;
    @(posedge clock); #1;
    drive(); drive();
    reset_n = 1'b1;
    drive();
    // load-use on rs2
    LoadE = 1; RdE = 5; Rs2D = 5; drive();
    idle(); drive();
    // mul/div: start, three wait cycles, done cycle
    MulDivE = 1; drive();
    repeat (3) drive();
    MdDone = 1; drive();
    idle(); MdDone = 1; drive();
    idle(); drive();
    // back-to-back mul/div
    MulDivE = 1; drive();
    MdDone = 1; drive();
    MdDone = 0; drive();
    MdDone = 1; drive();
    idle(); drive();
    // redirect while a fetch is outstanding
    ImemReadyF = 0; PCSrcE = 1; drive();
    PCSrcE = 0; drive();
    ImemReadyF = 1; drive();
    drive();
    // redirect repeated while discard pending
    ImemReadyF = 0; PCSrcE = 1; drive(); drive();
    PCSrcE = 0; ImemReadyF = 1; drive(); drive();
    // forwarding priority
    Rs1E = 7; Rs2E = 7; RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; drive();
    RegWriteM = 0; drive();
    Rs1E = 0; drive();
    RdM = 0; RegWriteM = 1; Rs2E = 0; Rs1E = 7; drive();
    // rd=x0 load never stalls
    idle(); LoadE = 1; RdE = 0; Rs1D = 0; drive();
    // counter saturation
    idle(); LoadE = 1; RdE = 5; Rs1D = 5; repeat (20) drive();
    idle(); drive();
    // reset in the middle of a mul/div wait
    MulDivE = 1; drive(); drive();
    reset_n = 0; drive(); drive();
    reset_n = 1; MulDivE = 0; drive();
    drive();
    repeat (3000) begin
      idle();
      Rs1D = REG_W'($urandom_range(0, 7)); Rs2D = REG_W'($urandom_range(0, 7));
      Rs1E = REG_W'($urandom_range(0, 7)); Rs2E = REG_W'($urandom_range(0, 7));
      RdE  = REG_W'($urandom_range(0, 7));
      RdM  = REG_W'($urandom_range(0, 7)); RdW = REG_W'($urandom_range(0, 7));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ImemReadyF = ($urandom_range(0, 3) != 0);
      MdDone = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 7);
      LoadE = (r < 2); MulDivE = (r == 2); PCSrcE = (r == 3);
      reset_n = ($urandom_range(0, 99) != 0);
      drive();
    end
    reset_n = 1;
    idle();
    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
